pitch_speed_smoother: RTL and testbench
=======================================

// Module: pitch_speed_smoother
// PURPOSE
//  Consumes FFT peak-bin frames from fft_pitch_detect (pitch_valid/pitch_data, adc_clk domain).
//  Smooths them with a DEPTH-frame moving average and maps the average to a 1..16 level.
//  Derives speed (0 idle / 1 slow / 2 fast) with hysteresis and a silence timeout.
//  Drives the motor/display logic downstream.
// PARAMETERS
//  BIN_W       10         width of pitch_data (clog2 of NSamples=1024)
//  MAX_BIN     300        bin mapped to level 16; inputs >= MAX_BIN clamp to MAX_BIN
//  DEPTH       4          moving-average length; power of 2, >= 2
//  FAST_ON     10         level >= FAST_ON enters FAST
//  FAST_OFF    7          level <= FAST_OFF leaves FAST (FAST_OFF < FAST_ON)
//  TIMEOUT_CYC 2_000_000  clk cycles with no pitch_valid before IDLE (~108 ms at 18.432 MHz)
// PORTS
//  clk          in   1      adc_clk, all logic on rising edge
//  reset        in   1      synchronous, active-high
//  pitch_valid  in   1      one-cycle strobe per FFT frame; accepted every cycle, no backpressure
//  pitch_data   in   BIN_W  peak bin index
//  level        out  5      smoothed level, 1..16; 0 when idle
//  level_valid  out  1      one-cycle pulse when level/speed updated from a frame
//  speed        out  2      2'd0 IDLE, 2'd1 SLOW, 2'd2 FAST; 2'd3 never driven
// BEHAVIOUR
//  Reset: level=0, level_valid=0, speed=0, state IDLE, buffer empty, timeout counter=0.
//  Input stage: x = min(pitch_data, MAX_BIN). Sum width = clog2(MAX_BIN*DEPTH+1); no overflow possible.
//  Ring buffer, DEPTH entries, write pointer wraps DEPTH-1 -> 0.
//  Buffer empty (after reset or timeout): first frame pre-fills all DEPTH entries with x; sum = x*DEPTH.
//  Buffer non-empty: sum <= sum - buf[wp] + x; buf[wp] <= x; wp++.
//  Pipeline: frame at cycle T -> sum valid T+1 -> level/speed/level_valid registered at T+2.
//   Latency 2. Back-to-back frames on consecutive cycles are each processed.
//  avg = sum >> log2(DEPTH) (floor). level = (avg >= MAX_BIN) ? 16 : (avg*15)/MAX_BIN + 1.
//   Integer floor; 5-bit result, so 16 does not wrap.
//  FSM, evaluated only on a level update:
//   IDLE: level >= FAST_ON -> FAST, else -> SLOW.
//   SLOW: level >= FAST_ON -> FAST.
//   FAST: level <= FAST_OFF -> SLOW.
//   FAST_OFF < level < FAST_ON: state held.
//   speed mirrors state in the same cycle level_valid is high.
//  Timeout counter: cleared on every pitch_valid; otherwise increments, saturating.
//   On reaching TIMEOUT_CYC: state IDLE, speed=0, level=0, buffer marked empty; no level_valid pulse.
//  pitch_valid in the expiry cycle: the frame wins; counter clears and IDLE is not entered.
//  Frames in the pipeline when timeout fires: they complete normally.
//   Their update re-enters SLOW/FAST per the IDLE rules.
//  reset mid-pipeline: in-flight frames are discarded; outputs return to reset values the next cycle.
// CONFIGURATION
//  SPEED_DEBOUNCE_EN defined:
//   - SLOW<->FAST changes require 2 consecutive level updates both satisfying the transition condition.
//   - A non-qualifying update clears the pending flag.
//   - IDLE exit and timeout entry remain immediate.
//  SPEED_DEBOUNCE_EN undefined: transitions are immediate on a single update, as described above.
// TESTING  (defaults, macro undefined unless stated)
//  1. Reset held 3 cycles -> level=0, speed=0, level_valid=0 throughout.
//  2. pitch_data=150 pulse at T -> at T+2: level_valid=1, level=8, speed=1.
//  3. After test 2, four frames of 300 -> levels 10,12,14,16; speed=2 from the first.
//     Then pitch_data=1023 -> clamped, level=16.
//  4. From FAST at level 16, frames of 120 -> levels 13,11,9,7; speed stays 2 until level 7, then 1.
//  5. TIMEOUT_CYC=100, no frames for 100 cycles -> speed=0, level=0, no pulse.
//     Then frame 60 -> level=4, speed=1.
//     Repeat with the frame landing on the expiry cycle -> speed never 0.
//  6. SPEED_DEBOUNCE_EN defined, rerun test 4 -> speed changes to 1 only after the second update <= 7.
//     One update <= 7 followed by level 9 -> speed stays 2.

Source files
------------

// File: rtl/pitch_speed_smoother_if.sv
// Purpose: frame-in / level-out bundle between fft_pitch_detect, the smoother and motor/display logic.
// Latency: none (wires only).
// Backpressure: none; every pitch_valid strobe is taken.
// Ports:
//   pitch_valid  one-cycle strobe per FFT frame
//   pitch_data   peak bin index (BIN_W bits)
//   level        smoothed level 1..16, 0 when idle
//   level_valid  one-cycle pulse per level/speed update
//   speed        0 idle, 1 slow, 2 fast
// Modports: master = frame producer / level consumer, slave = the smoother.
interface pitch_speed_smoother_if #(
  parameter int BIN_W = 10
) ();
  logic             pitch_valid;
  logic [BIN_W-1:0] pitch_data;
  logic [4:0]       level;
  logic             level_valid;
  logic [1:0]       speed;

  modport master (
    output pitch_valid, pitch_data,
    input  level, level_valid, speed
  );

  modport slave (
    input  pitch_valid, pitch_data,
    output level, level_valid, speed
  );
endinterface

// File: rtl/pitch_speed_smoother.sv
// Purpose: DEPTH-frame moving average of FFT peak bins -> level 1..16 and speed (idle/slow/fast).
// Latency: 2 cycles from pitch_valid to level_valid; one frame per cycle sustained.
// Backpressure: none; every frame is accepted, silence timeout forces idle.
// Ports: clk (adc_clk domain), reset (sync, active-high), bus (pitch_speed_smoother_if.slave).
// Optional feature macro: SPEED_DEBOUNCE_EN -- SLOW<->FAST needs two consecutive qualifying updates.
module pitch_speed_smoother #(
  parameter int BIN_W       = 10,
  parameter int MAX_BIN     = 300,
  parameter int DEPTH       = 4,
  parameter int FAST_ON     = 10,
  parameter int FAST_OFF    = 7,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic clk,
  input logic reset,
  pitch_speed_smoother_if.slave bus
);

  localparam int XW    = $clog2(MAX_BIN + 1);
  localparam int SUM_W = $clog2(MAX_BIN * DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LOG2D = $clog2(DEPTH);
  localparam int PW    = SUM_W + 4;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BIN_W-1:0] MAX_BIN_B = BIN_W'(MAX_BIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_t;

  logic [XW-1:0]    x;
  logic [XW-1:0]    ring_q [DEPTH];
  logic [PTR_W-1:0] wp_q;
  logic             empty_q;
  logic [SUM_W-1:0] sum_q;
  logic             sum_vld_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             expire;
  logic [SUM_W-1:0] avg;
  logic [PW-1:0]    scaled;
  logic [4:0]       lvl_calc;
  state_t           state_q;
  state_t           src_state;
  logic [4:0]       level_q;
  logic             level_vld_q;
`ifdef SPEED_DEBOUNCE_EN
  logic             db_pend_q;
`endif

  // Clamp so the running sum can never exceed MAX_BIN*DEPTH.
  always_comb begin
    x = (bus.pitch_data >= MAX_BIN_B) ? XW'(MAX_BIN) : XW'(bus.pitch_data);
  end

  // Fires once, on the cycle the silent-cycle count would reach TIMEOUT_CYC.
  // A frame arriving in that same cycle suppresses it.
  assign expire = !bus.pitch_valid && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Input stage: ring buffer, running sum, silence counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q      <= '0;
      empty_q   <= 1'b1;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      sum_vld_q <= bus.pitch_valid;
      if (bus.pitch_valid) begin
        to_cnt_q <= '0;
        if (empty_q) begin
          // First frame after reset/timeout stands in for the whole window.
          for (int i = 0; i < DEPTH; i++) ring_q[i] <= x;
          sum_q   <= SUM_W'(x) << LOG2D;
          empty_q <= 1'b0;
        end else begin
          ring_q[wp_q] <= x;
          sum_q        <= sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(x);
          wp_q         <= wp_q + PTR_W'(1);
        end
      end else begin
        if (to_cnt_q != TO_W'(TIMEOUT_CYC)) to_cnt_q <= to_cnt_q + TO_W'(1);
        if (expire) empty_q <= 1'b1;
      end
    end
  end

  // Average -> level. Below MAX_BIN the quotient is at most 14, so level stays 1..15 there.
  always_comb begin
    avg      = sum_q >> LOG2D;
    scaled   = (PW'(avg) * PW'(15)) / PW'(MAX_BIN);
    lvl_calc = (avg >= SUM_W'(MAX_BIN)) ? 5'd16 : 5'(scaled + PW'(1));
  end

  // An update landing together with a timeout is judged from IDLE.
  always_comb begin
    src_state = expire ? ST_IDLE : state_q;
  end

  // Output stage and speed FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      level_vld_q <= 1'b0;
`ifdef SPEED_DEBOUNCE_EN
      db_pend_q   <= 1'b0;
`endif
    end else begin
      level_vld_q <= sum_vld_q;
      if (sum_vld_q) begin
        level_q <= lvl_calc;
        case (src_state)
          ST_IDLE: begin
            state_q <= (lvl_calc >= 5'(FAST_ON)) ? ST_FAST : ST_SLOW;
`ifdef SPEED_DEBOUNCE_EN
            db_pend_q <= 1'b0;
`endif
          end
          ST_SLOW: begin
`ifdef SPEED_DEBOUNCE_EN
            if (lvl_calc >= 5'(FAST_ON)) begin
              if (db_pend_q) begin
                state_q   <= ST_FAST;
                db_pend_q <= 1'b0;
              end else begin
                db_pend_q <= 1'b1;
              end
            end else begin
              db_pend_q <= 1'b0;
            end
`else
            if (lvl_calc >= 5'(FAST_ON)) state_q <= ST_FAST;
`endif
          end
          ST_FAST: begin
`ifdef SPEED_DEBOUNCE_EN
            if (lvl_calc <= 5'(FAST_OFF)) begin
              if (db_pend_q) begin
                state_q   <= ST_SLOW;
                db_pend_q <= 1'b0;
              end else begin
                db_pend_q <= 1'b1;
              end
            end else begin
              db_pend_q <= 1'b0;
            end
`else
            if (lvl_calc <= 5'(FAST_OFF)) state_q <= ST_SLOW;
`endif
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (expire) begin
        state_q <= ST_IDLE;
        level_q <= '0;
`ifdef SPEED_DEBOUNCE_EN
        db_pend_q <= 1'b0;
`endif
      end
    end
  end

  assign bus.level       = level_q;
  assign bus.level_valid = level_vld_q;
  assign bus.speed       = state_q;

endmodule

// File: tb/tb_pitch_speed_smoother.sv
// Purpose: self-checking bench for pitch_speed_smoother with a frame-level reference model.
// Latency: model expects updates two cycles after each accepted frame.
// Backpressure: none; stimulus is one optional frame per cycle.
module tb_pitch_speed_smoother;
  localparam int MAX_BIN  = 300;
  localparam int DEPTH    = 4;
  localparam int FAST_ON  = 10;
  localparam int FAST_OFF = 7;
  localparam int TO       = 100;
`ifdef SPEED_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pitch_speed_smoother_if #(.BIN_W(10)) bus ();

  pitch_speed_smoother #(
    .BIN_W(10), .MAX_BIN(MAX_BIN), .DEPTH(DEPTH),
    .FAST_ON(FAST_ON), .FAST_OFF(FAST_OFF), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: window as a plain queue of clamped frames.
  int hist[$];
  bit m_empty = 1'b1;
  int m_quiet = 0;
  bit m_pend = 1'b0;
  int m_pend_lvl = 0;
  int m_state = 0;
  int m_level = 0;
  bit m_lv = 1'b0;
  bit m_dbp = 1'b0;

  task automatic check(string name, bit ok, int got, int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic lit(string name, int got, int exp);
    check(name, got == exp, got, exp);
  endtask

  function automatic int lvl_of(int avg);
    if (avg >= MAX_BIN) return 16;
    return (avg * 15) / MAX_BIN + 1;
  endfunction

  task automatic model_fsm(int lvl);
    if (m_state == 0) begin
      m_state = (lvl >= FAST_ON) ? 2 : 1;
      m_dbp = 1'b0;
    end else begin
      bit want;
      want = (m_state == 1) ? (lvl >= FAST_ON) : (lvl <= FAST_OFF);
      if (!want) m_dbp = 1'b0;
      else if (!DB || m_dbp) begin
        m_state = (m_state == 1) ? 2 : 1;
        m_dbp = 1'b0;
      end else m_dbp = 1'b1;
    end
  endtask

  // Called once per rising edge with the inputs that edge sampled.
  task automatic model_edge(bit v, int d, bit r);
    int x;
    int s;
    if (r) begin
      hist.delete();
      m_empty = 1'b1; m_quiet = 0; m_pend = 1'b0; m_pend_lvl = 0;
      m_state = 0; m_level = 0; m_lv = 1'b0; m_dbp = 1'b0;
      return;
    end
    m_lv = 1'b0;
    if (!v && (m_quiet + 1 == TO)) begin
      m_state = 0; m_level = 0; m_empty = 1'b1; m_dbp = 1'b0;
    end
    if (m_pend) begin
      m_level = m_pend_lvl;
      m_lv = 1'b1;
      model_fsm(m_pend_lvl);
    end
    m_pend = 1'b0;
    if (v) begin
      x = (d > MAX_BIN) ? MAX_BIN : d;
      if (m_empty) begin
        hist.delete();
        repeat (DEPTH) hist.push_back(x);
        m_empty = 1'b0;
      end else begin
        void'(hist.pop_front());
        hist.push_back(x);
      end
      s = 0;
      foreach (hist[k]) s += hist[k];
      m_pend = 1'b1;
      m_pend_lvl = lvl_of(s / DEPTH);
      m_quiet = 0;
    end else if (m_quiet < 1_000_000) begin
      m_quiet++;
    end
  endtask

  // Drive one cycle; returns 1 time unit after the edge that consumed the inputs.
  task automatic step(bit v, int d, bit r);
    bus.pitch_valid = v;
    bus.pitch_data  = 10'(d);
    reset           = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
  endtask

  // Single frame followed by two quiet cycles; checks the update pulse.
  task automatic frame_chk(int d, int exp_lvl, int exp_spd);
    step(1'b1, d, 1'b0);
    step(1'b0, 0, 1'b0);
    lit("upd_valid", int'(bus.level_valid), 1);
    lit("upd_level", int'(bus.level), exp_lvl);
    lit("upd_speed", int'(bus.speed), exp_spd);
    step(1'b0, 0, 1'b0);
    lit("pulse_width", int'(bus.level_valid), 0);
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_level", int'(bus.level) == m_level, int'(bus.level), m_level);
        check("cyc_level_valid", int'(bus.level_valid) == int'(m_lv), int'(bus.level_valid), int'(m_lv));
        check("cyc_speed", int'(bus.speed) == m_state, int'(bus.speed), m_state);
      end
    end
  end

  initial begin
    bus.pitch_valid = 1'b0;
    bus.pitch_data  = '0;
    reset           = 1'b1;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b1);
      chk_en = 1'b1;
      lit("rst_level", int'(bus.level), 0);
      lit("rst_speed", int'(bus.speed), 0);
      lit("rst_valid", int'(bus.level_valid), 0);
    end

    // First frame into an empty window, then a ramp to saturation and a clamped bin.
    step(1'b0, 0, 1'b0);
    frame_chk(150, 8, 1);
    frame_chk(300, 10, DB ? 1 : 2);
    frame_chk(300, 12, 2);
    frame_chk(300, 14, 2);
    frame_chk(300, 16, 2);
    frame_chk(1023, 16, 2);

    // Descent through the hysteresis band.
    frame_chk(120, 13, 2);
    frame_chk(120, 11, 2);
    frame_chk(120, 9, 2);
    frame_chk(120, 7, DB ? 2 : 1);
    frame_chk(120, 7, 1);

    // Silence timeout: one cycle short holds, the expiry cycle drops to idle silently.
    for (int i = 0; i < TO - 3; i++) step(1'b0, 0, 1'b0);
    lit("pre_timeout_speed", int'(bus.speed), 1);
    lit("pre_timeout_level", int'(bus.level), 7);
    step(1'b0, 0, 1'b0);
    lit("timeout_speed", int'(bus.speed), 0);
    lit("timeout_level", int'(bus.level), 0);
    lit("timeout_no_pulse", int'(bus.level_valid), 0);
    frame_chk(60, 4, 1);

    // Frame on the expiry cycle wins.
    for (int i = 0; i < TO - 3; i++) step(1'b0, 0, 1'b0);
    step(1'b1, 60, 1'b0);
    lit("expiry_frame_speed", int'(bus.speed), 1);
    step(1'b0, 0, 1'b0);
    lit("expiry_frame_valid", int'(bus.level_valid), 1);
    lit("expiry_frame_level", int'(bus.level), 4);
    step(1'b0, 0, 1'b0);

    // Re-enter FAST, then a single low update followed by a held-band update.
    frame_chk(300, 7, 1);
    frame_chk(300, 10, DB ? 1 : 2);
    frame_chk(300, 13, 2);
    frame_chk(300, 16, 2);
    frame_chk(0, 12, 2);
    frame_chk(210, 11, 2);
    frame_chk(210, 10, 2);
    frame_chk(0, 6, DB ? 2 : 1);
    frame_chk(250, 9, DB ? 2 : 1);
    frame_chk(0, 6, DB ? 2 : 1);

    // Back-to-back frames, mid-pipeline reset.
    step(1'b1, 200, 1'b0);
    step(1'b1, 40, 1'b0);
    step(1'b1, 300, 1'b1);
    step(1'b0, 0, 1'b0);
    lit("mid_reset_valid", int'(bus.level_valid), 0);
    lit("mid_reset_level", int'(bus.level), 0);

    // Randomized traffic with occasional silences long enough to time out.
    for (int i = 0; i < 40; i++) begin
      int gap;
      for (int j = 0; j < 60; j++) begin
        step($urandom_range(0, 2) != 0,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(301, 1023)) : int'($urandom_range(0, 300)),
             $urandom_range(0, 99) == 0);
      end
      gap = ($urandom_range(0, 1) != 0) ? int'($urandom_range(95, 105)) : 3;
      for (int j = 0; j < gap; j++) step(1'b0, 0, 1'b0);
    end

    step(1'b0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
